// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants and types for the 5-stage pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline stage info in, hold/clear/forward controls out.
// Performance counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E, Rs2E, RdE;
  logic                  ResultSrcE0;
  logic                  PCSrcE;
  logic [REG_ADDR_W-1:0] RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  logic                  DMemReqM, DMemReadyM;

  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           StallCycleCnt, FlushCycleCnt, MemWaitCnt;
`endif

  // Pipeline side: supplies stage state, consumes the controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, DMemReqM, DMemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    , input StallCycleCnt, FlushCycleCnt, MemWaitCnt
`endif
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, DMemReqM, DMemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    , output StallCycleCnt, FlushCycleCnt, MemWaitCnt
`endif
  );

endinterface

// File: rtl/pipeline_hazard_controller_forward_sel.sv
// E-stage operand forwarding select; the M-stage result is newer than W, so it wins.
module hazard_forward_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic [1:0]            sel
);

  logic rs_nonzero;

  // x0 is hardwired to zero and must never be forwarded.
  assign rs_nonzero = (RsE != '0);

  always_comb begin
    if (RegWriteM && (RdM == RsE) && rs_nonzero)      sel = FWD_M;
    else if (RegWriteW && (RdW == RsE) && rs_nonzero) sel = FWD_W;
    else                                              sel = FWD_RF;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for the F/D/E/M/W pipeline with a memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_CNT_W = 8
) (
  input logic                       clk,
  input logic                       rst,
  pipeline_hazard_controller_if.slave hz
);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;

  logic       mem_busy, freeze, load_use;
  logic [1:0] fwd_a, fwd_b;

  assign mem_busy = hz.DMemReqM & ~hz.DMemReadyM;
  assign freeze   = mem_busy | (state_q == ERROR);
  assign load_use = hz.ResultSrcE0 && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  hazard_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .RsE(hz.Rs1E), .RdM(hz.RdM), .RdW(hz.RdW),
    .RegWriteM(hz.RegWriteM), .RegWriteW(hz.RegWriteW), .sel(fwd_a)
  );

  hazard_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .RsE(hz.Rs2E), .RdM(hz.RdM), .RdW(hz.RdW),
    .RegWriteM(hz.RegWriteM), .RegWriteW(hz.RegWriteW), .sel(fwd_b)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT)) begin
          state_d       = ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // A freeze leaves FlushD/FlushE low so a pending branch or load-use is serviced after release.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (rst) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushW = 1'b1;
    end else if (freeze) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (load_use) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hz.MemTimeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] mwait_cnt_q, mwait_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, hz.StallF};
    flush_cnt_d = flush_cnt_q + {31'd0, hz.FlushE & ~rst};
    mwait_cnt_d = mwait_cnt_q + {31'd0, mem_busy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mwait_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mwait_cnt_q <= mwait_cnt_d;
    end
  end

  assign hz.StallCycleCnt = stall_cnt_q;
  assign hz.FlushCycleCnt = flush_cnt_q;
  assign hz.MemWaitCnt    = mwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller; inputs change on negedge,
// outputs are checked 1 ns later, well clear of the rising edge.
module tb_pipeline_hazard_controller;

  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.REG_ADDR_W(5)) hz ();

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
  task automatic check_ctl(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW}, {25'd0, exp});
  endtask

  task automatic idle_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
    hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.DMemReqM = 1'b0; hz.DMemReadyM = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();

    // Reset: forwarding inputs would match, but outputs must be in their reset values.
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
    step(); #1;
    check_ctl("reset_ctl", 7'b0000_111);
    check("reset_fwd_a", {30'd0, hz.ForwardAE}, 32'd0);
    check("reset_timeout", {31'd0, hz.MemTimeout}, 32'd0);

    step(); rst = 1'b0; idle_inputs(); #1;
    check_ctl("idle_ctl", 7'b0000_000);

    // Forwarding priority and x0 exclusion.
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RdM = 5'd5; hz.RdW = 5'd5;
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; #1;
    check("fwd_a_m_over_w", {30'd0, hz.ForwardAE}, 32'd2);
    check("fwd_b_m_over_w", {30'd0, hz.ForwardBE}, 32'd2);
    hz.RegWriteM = 1'b0; #1;
    check("fwd_a_w", {30'd0, hz.ForwardAE}, 32'd1);
    hz.RegWriteM = 1'b1; hz.Rs1E = 5'd0; #1;
    check("fwd_a_x0", {30'd0, hz.ForwardAE}, 32'd0);
    check("fwd_b_still_m", {30'd0, hz.ForwardBE}, 32'd2);
    hz.Rs2E = 5'd9; hz.RdW = 5'd9; #1;
    check("fwd_b_w_other_reg", {30'd0, hz.ForwardBE}, 32'd1);

    // Load-use, then load-use together with a taken branch.
    step(); idle_inputs();
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; #1;
    check_ctl("load_use", 7'b1100_010);
    hz.PCSrcE = 1'b1; #1;
    check_ctl("load_use_branch", 7'b0000_110);
    hz.PCSrcE = 1'b0; hz.RdE = 5'd0; hz.Rs2D = 5'd0; #1;
    check_ctl("load_x0_no_stall", 7'b0000_000);

    // Three-cycle memory wait, released the cycle DMemReadyM rises.
    step(); idle_inputs();
    hz.DMemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1 check_ctl($sformatf("mem_wait_c%0d", i), 7'b1111_001);
    end
    step(); hz.DMemReadyM = 1'b1; #1;
    check_ctl("mem_release", 7'b0000_000);
    step(); idle_inputs(); #1;
    check_ctl("mem_after_run", 7'b0000_000);
    check("mem_no_timeout", {31'd0, hz.MemTimeout}, 32'd0);

    // Branch held across a two-cycle wait is serviced on release.
    step(); hz.PCSrcE = 1'b1; hz.DMemReqM = 1'b1; #1;
    check_ctl("br_wait_c0", 7'b1111_001);
    step(); #1;
    check_ctl("br_wait_c1", 7'b1111_001);
    step(); hz.DMemReadyM = 1'b1; #1;
    check_ctl("br_release", 7'b0000_110);

    // Watchdog: MAX_WAIT+1 busy cycles trip the sticky timeout.
    step(); idle_inputs(); hz.DMemReqM = 1'b1;
    for (int i = 0; i < MAX_WAIT + 1; i++) begin
      if (i > 0) step();
      if (i == MAX_WAIT) #1 check("timeout_not_yet", {31'd0, hz.MemTimeout}, 32'd0);
    end
    step(); #1;
    check("timeout_set", {31'd0, hz.MemTimeout}, 32'd1);
    hz.DMemReqM = 1'b0; #1;
    check_ctl("error_freeze", 7'b1111_001);
    step(); #1;
    check("timeout_sticky", {31'd0, hz.MemTimeout}, 32'd1);
    rst = 1'b1; #1;
    check("timeout_cleared", {31'd0, hz.MemTimeout}, 32'd0);
    check_ctl("reset_in_error", 7'b0000_111);
    step(); rst = 1'b0; #1;
    check_ctl("run_after_reset", 7'b0000_000);

`ifdef HAZARD_PERF_CNT_EN
    // Counters: two load-use cycles and one four-cycle wait after a fresh reset.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
    step(); step(); idle_inputs();
    hz.DMemReqM = 1'b1;
    step(); step(); step(); step(); idle_inputs();
    step(); #1;
    check("perf_stall", hz.StallCycleCnt, 32'd6);
    check("perf_memwait", hz.MemWaitCnt, 32'd4);
    check("perf_flush", hz.FlushCycleCnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Hazard and stall sequencer for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Drives the hold and clear inputs of the inter-stage pipeline registers. Active-high hold means the register keeps its value; clear means the register is zeroed.
- Produces the E-stage forwarding selects.
- Runs a small FSM that freezes the pipeline while a multi-cycle data-memory access is outstanding, with a watchdog timeout.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MAX_WAIT, 16, maximum number of consecutive memory-wait cycles before timeout (1..2^WAIT_CNT_W-1).
- WAIT_CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  sources and destination of the instruction in E.
- ResultSrcE0  in  1  instruction in E is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- RdM, RdW  in  REG_ADDR_W  destinations in M and W.
- RegWriteM, RegWriteW  in  1  register writes pending in M and W.
- DMemReqM  in  1  M-stage data-memory access active.
- DMemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC, FD, DE and EM registers.
- FlushD, FlushE, FlushW  out  1  clear the FD, DE and MW registers.
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALU result from M, 01 = result from W.
- MemTimeout  out  1  sticky watchdog error flag.

Behaviour:
- All stall, flush and forward outputs are combinational from the inputs and the registered state.
- The state register, wait counter and MemTimeout are updated on posedge clk or posedge rst.
- While rst=1:
  - state=RUN, wait counter=0, MemTimeout=0.
  - Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
- Forwarding for ForwardAE (ForwardBE is identical using Rs2E):
  - 10 if RegWriteM, RdM==Rs1E and Rs1E!=0.
  - Otherwise 01 if RegWriteW, RdW==Rs1E and Rs1E!=0.
  - Otherwise 00.
  - M takes priority over W.
- MemBusy = DMemReqM & ~DMemReadyM.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN, MemBusy=1: go to MEM_WAIT; counter loads 1.
  - RUN, MemBusy=0: stay in RUN; counter=0.
  - MEM_WAIT, MemBusy=0: go to RUN; counter clears.
  - MEM_WAIT, MemBusy=1 and counter==MAX_WAIT: go to ERROR; MemTimeout set.
  - MEM_WAIT, MemBusy=1 otherwise: counter increments.
  - ERROR: exited only by rst.
- Freeze condition = MemBusy, or state==ERROR.
  - StallF=StallD=StallE=StallM=1 and FlushW=1 (a bubble enters W).
  - FlushD=FlushE=0: a pending branch or load-use stays held in E/D and is serviced once the freeze ends.
  - The freeze applies in the same cycle MemBusy first rises (zero latency).
  - The pipeline releases in the same cycle DMemReadyM rises.
- When not frozen (StallE=StallM=FlushW=0):
  - Load-use hazard = ResultSrcE0, RdE!=0, and (Rs1D==RdE or Rs2D==RdE).
  - Branch: PCSrcE=1 gives FlushD=1 and FlushE=1.
  - Load-use with no branch: StallF=1, StallD=1, FlushE=1 (one-cycle bubble).
  - Load-use and PCSrcE together: the branch wins, so StallF=StallD=0 and FlushD=FlushE=1.
- Forwarding is computed in every state, including while frozen.
- Reset in the middle of MEM_WAIT or ERROR returns the block to RUN immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three extra 32-bit outputs are added:
  - StallCycleCnt: counts cycles with StallF=1.
  - FlushCycleCnt: counts cycles with FlushE=1 while not in reset.
  - MemWaitCnt: counts cycles with MemBusy=1.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - FSM state typedef: RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2.
- One combinational sub-module, hazard_forward_sel, instantiated twice (once for operand A, once for B).
  - Inputs: RsE, RdM, RdW, RegWriteM, RegWriteW.
  - Output: a 2-bit select.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With Rs1E=0 and the same inputs -> ForwardAE=00.
- ResultSrcE0=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0. With PCSrcE=1 added -> FlushD=FlushE=1, StallF=0.
- DMemReqM=1 with DMemReadyM low for 3 cycles, then high:
  - All stalls and FlushW=1 for exactly 3 cycles.
  - State returns to RUN, MemTimeout=0.
- PCSrcE=1 held during a 2-cycle memory wait -> FlushD=FlushE=0 during the wait; both become 1 in the release cycle.
- MemBusy held for MAX_WAIT+1 cycles -> MemTimeout=1, permanent freeze. Then assert rst -> MemTimeout=0, state RUN, FlushD=FlushE=FlushW=1 during reset.
- With HAZARD_PERF_CNT_EN: run 2 load-use stalls and 1 four-cycle memory wait -> StallCycleCnt=6, MemWaitCnt=4, FlushCycleCnt=2.
